// File: rtl/lut_neuron_stream.sv
// Runtime-programmable truth-table neuron: a RAM-backed lookup table with a
// two-stage valid/ready pipeline and a LOAD/RUN/DRAIN reload controller.
module lut_neuron_stream #(
  parameter int FAN_IN   = 4,
  parameter int IN_BITS  = 2,
  parameter int OUT_BITS = 2,
  localparam int ADDR_W  = FAN_IN * IN_BITS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_start,
  input  logic                cfg_we,
  input  logic [ADDR_W-1:0]   cfg_addr,
  input  logic [OUT_BITS-1:0] cfg_data,
  input  logic                cfg_done,
  output logic                cfg_err,
  output logic [1:0]          mode,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [ADDR_W-1:0]   in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [OUT_BITS-1:0] out_data
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    LOAD  = 2'b00,
    RUN   = 2'b01,
    DRAIN = 2'b10
  } mode_t;

  mode_t               state;
  logic [OUT_BITS-1:0] tbl [DEPTH];
  logic                v1;
  logic [ADDR_W-1:0]   a1;
  logic                v2;
  logic                in_fire;
  logic                st2_load;
  logic                tbl_we;

  // Handshakes: a beat transfers on a rising edge where valid && ready; the
  // producer holds valid/data until then, and ready never waits on valid.
  assign in_ready  = (state == RUN) && (!v1 || !v2 || out_ready);
  assign in_fire   = in_valid && in_ready;
  assign st2_load  = v1 && (!v2 || out_ready);
  assign tbl_we    = cfg_we && (state == LOAD);
  assign mode      = state;
  assign out_valid = v2;

  // Table contents deliberately survive rst so a reset can resume with the old table.
  always_ff @(posedge clk) begin
    if (tbl_we) tbl[cfg_addr] <= cfg_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= LOAD;
      cfg_err <= 1'b0;
    end else begin
      if (cfg_we && state != LOAD) cfg_err <= 1'b1;
      case (state)
        LOAD:    if (cfg_done) state <= RUN;
        RUN:     if (cfg_start) state <= DRAIN;
        DRAIN:   if (!v1 && !v2) state <= LOAD;
        default: state <= LOAD;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1       <= 1'b0;
      a1       <= '0;
      v2       <= 1'b0;
      out_data <= '0;
    end else begin
      if (in_fire) begin
        v1 <= 1'b1;
        a1 <= in_data;
      end else if (st2_load) begin
        v1 <= 1'b0;
      end
      if (st2_load) begin
        v2       <= 1'b1;
        out_data <= tbl[a1];
      end else if (out_ready) begin
        v2 <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_lut_neuron_stream.sv
// Scoreboarded bench for lut_neuron_stream: directed beats push expected
// results; an independent monitor pops and compares every delivered beat.
module tb_lut_neuron_stream;

  localparam int ADDR_W = 8;
  localparam int OB     = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              cfg_start, cfg_we, cfg_done;
  logic [ADDR_W-1:0] cfg_addr;
  logic [OB-1:0]     cfg_data;
  logic              cfg_err;
  logic [1:0]        mode;
  logic              in_valid, in_ready;
  logic [ADDR_W-1:0] in_data;
  logic              out_valid, out_ready;
  logic [OB-1:0]     out_data;

  logic [OB-1:0] exp_q[$];
  int            cyc_q[$];
  int            cyc = 0;
  int            n_checks = 0;
  int            n_pass = 0;

  lut_neuron_stream dut (
    .clk(clk), .rst(rst),
    .cfg_start(cfg_start), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .cfg_done(cfg_done), .cfg_err(cfg_err),
    .mode(mode),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string name, int act, int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endfunction

  // scoreboard monitor: a beat is consumed at the posedge following this negedge
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out", 1, 0);
      end else begin
        logic [OB-1:0] e;
        int            ec;
        e  = exp_q.pop_front();
        ec = cyc_q.pop_front();
        check("out_data", int'(out_data), int'(e));
        if (ec >= 0) check("out_latency", cyc, ec);
      end
    end
  end

  // driver tasks
  task automatic cfg_write(input logic [ADDR_W-1:0] a, input logic [OB-1:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  task automatic pulse_done();
    cfg_done = 1'b1;
    @(posedge clk); #1;
    cfg_done = 1'b0;
  endtask

  task automatic pulse_start();
    cfg_start = 1'b1;
    @(posedge clk); #1;
    cfg_start = 1'b0;
  endtask

  task automatic send(input logic [ADDR_W-1:0] a, input logic [OB-1:0] e, input bit lat);
    bit done = 1'b0;
    in_valid = 1'b1; in_data = a;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(e);
        cyc_q.push_back(lat ? cyc + 2 : -1);
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    if (!done) check("send_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int i = 0;
    while (exp_q.size() != 0 && i < 50) begin
      @(negedge clk);
      i++;
    end
    check("drain_timeout", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; cfg_start = 1'b0; cfg_we = 1'b0; cfg_done = 1'b0;
    cfg_addr = '0; cfg_data = '0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_mode", mode, 0);
    check("rst_cfg_err", cfg_err, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // default table: t[a] = a[1:0] ^ a[7:6]
    for (int a = 0; a < 256; a++) begin
      logic [7:0] av;
      av = a[7:0];
      cfg_write(av, av[1:0] ^ av[7:6]);
    end
    pulse_done();
    @(negedge clk);
    check("mode_run", mode, 1);
    @(posedge clk); #1;

    // back-to-back streaming, 2-cycle latency
    out_ready = 1'b1;
    send(8'h03, 2'b11, 1'b1);
    send(8'hC3, 2'b00, 1'b1);
    send(8'h41, 2'b00, 1'b1);
    wait_drain();

    // backpressure: two beats buffered, third stalls
    out_ready = 1'b0;
    send(8'h03, 2'b11, 1'b0);
    send(8'hC3, 2'b00, 1'b0);
    in_valid = 1'b1; in_data = 8'h41;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("bp_in_ready", in_ready, 0);
      check("bp_out_valid", out_valid, 1);
      check("bp_out_data", out_data, 3);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    send(8'h41, 2'b00, 1'b0);
    wait_drain();

    // cfg_we during RUN: sticky error, table untouched
    cfg_write(8'h00, 2'b10);
    @(negedge clk);
    check("cfg_err_set", cfg_err, 1);
    repeat (3) @(posedge clk);
    #1;
    check("cfg_err_sticky", cfg_err, 1);
    send(8'h00, 2'b00, 1'b1);
    wait_drain();

    // reset with two beats buffered; table retained
    out_ready = 1'b0;
    send(8'h03, 2'b11, 1'b0);
    send(8'hC3, 2'b00, 1'b0);
    rst = 1'b1;
    exp_q.delete();
    cyc_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_mode", mode, 0);
    check("midrst_cfg_err", cfg_err, 0);
    @(posedge clk); #1;
    pulse_done();
    out_ready = 1'b1;
    send(8'h03, 2'b11, 1'b1);
    wait_drain();

    // drain with two beats in flight, then reload one entry
    out_ready = 1'b0;
    send(8'h03, 2'b11, 1'b0);
    send(8'h41, 2'b00, 1'b0);
    pulse_start();
    @(negedge clk);
    check("drain_mode", mode, 2);
    check("drain_in_ready", in_ready, 0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    begin
      int i = 0;
      do begin
        @(negedge clk);
        i++;
      end while (out_valid && i < 20);
      check("drain_empty_timeout", int'(out_valid), 0);
      check("drain_last_cycle", mode, 2);
      check("drained_queue", exp_q.size(), 0);
    end
    @(posedge clk); #1;
    check("load_after_drain", mode, 0);
    cfg_write(8'h03, 2'b01);
    pulse_done();
    send(8'h03, 2'b01, 1'b1);
    wait_drain();

    // empty-pipe drain lasts one cycle; write + done in the same cycle
    pulse_start();
    check("empty_drain", mode, 2);
    @(posedge clk); #1;
    check("empty_drain_load", mode, 0);
    cfg_we = 1'b1; cfg_addr = 8'hFF; cfg_data = 2'b10; cfg_done = 1'b1;
    @(posedge clk); #1;
    cfg_we = 1'b0; cfg_done = 1'b0;
    check("we_done_mode", mode, 1);
    send(8'hFF, 2'b10, 1'b1);
    wait_drain();

    repeat (3) @(posedge clk);
    #1;
    check("final_queue", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/lut_neuron_stream.md
Name: lut_neuron_stream

Overview:
- Parametrised, runtime-programmable truth-table neuron with a registered valid/ready streaming datapath.
- Successor to the fixed-table combinational neuron ROMs: the table is held in distributed RAM and loaded through a config port, so layers can be retrained without regenerating RTL.
- Sits between layer register stages; one instance per neuron.
- A small FSM serialises table reload against in-flight traffic.

Parameters:
- FAN_IN, 4, number of neuron inputs.
- IN_BITS, 2, bits per quantised input.
- OUT_BITS, 2, bits of quantised output.
- ADDR_W (localparam), FAN_IN*IN_BITS, table address width; table depth is 2**ADDR_W.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- cfg_start  in  1  request entry to LOAD mode.
- cfg_we  in  1  table write strobe.
- cfg_addr  in  ADDR_W  table write address.
- cfg_data  in  OUT_BITS  table write data.
- cfg_done  in  1  commit table, return to RUN.
- cfg_err  out  1  sticky: cfg_we seen outside LOAD.
- mode  out  2  00 LOAD, 01 RUN, 10 DRAIN.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid&&in_ready.
- in_data  in  ADDR_W  packed inputs; input i at bits [i*IN_BITS +: IN_BITS]; used directly as table address.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accept.
- out_data  out  OUT_BITS  table[in_data] for the accepted beat.

Behaviour:
- Reset values: mode=LOAD, cfg_err=0, in_ready=0, out_valid=0, out_data=0, both pipeline valid bits cleared. Table RAM contents are not cleared by rst.
- FSM transitions:
  - LOAD: cfg_done -> RUN.
  - RUN: cfg_start -> DRAIN.
  - DRAIN: pipeline empty (v1=0 and v2=0) -> LOAD. If already empty on entry, DRAIN lasts exactly 1 cycle.
  - cfg_start outside RUN and cfg_done outside LOAD are ignored.
- Table writes:
  - Write table[cfg_addr]=cfg_data at the clock edge when cfg_we=1 and mode==LOAD, including the same cycle as cfg_done (the write lands, then RUN).
  - cfg_we in RUN or DRAIN: no write; cfg_err<=1. cfg_err is cleared only by rst.
- Pipeline:
  - Stage 1 registers the address (v1, a1).
  - Stage 2 does an asynchronous RAM read of a1 and registers the result into out_data/out_valid (v2).
  - Stage 2 loads when v1 && (!v2 || out_ready).
  - Stage 1 loads when in_valid && in_ready.
  - in_ready = (mode==RUN) && (!v1 || !v2 || out_ready). It is combinational from out_ready and from no other input.
- Latency and throughput: the beat accepted at edge N appears with out_valid=1 after edge N+1 (2-cycle latency). Throughput is 1 beat/cycle while out_ready=1.
- Backpressure: with out_ready=0, out_data/out_valid hold stable. Up to 2 beats are buffered (stage 1 and stage 2); then in_ready=0. No beat is dropped or duplicated. Ordering is preserved.
- Simultaneous events:
  - cfg_start with an input handshake in the same cycle: the beat is accepted and drains normally.
  - DRAIN keeps delivering buffered beats as out_ready allows.
- Reset mid-operation: in-flight beats are discarded; out_valid=0 in the cycle after rst is sampled; mode=LOAD. The table retains its prior contents, so cfg_done alone re-enters RUN with the old table.
- Width rules: no arithmetic on data. cfg_addr and in_data are full-range with no wrap or bounds check required.

Test Plan:
- Load all 256 entries with table[a]=a[1:0]^a[7:6] (defaults); cfg_done; stream 8'h03, 8'hC3, 8'h41 with out_ready=1 -> out_data 2'b11, 2'b00, 2'b00, each 2 cycles after its accept, back-to-back.
- Same table; hold out_ready=0 and drive 3 beats -> in_ready falls after 2 accepts, out_data=2'b11 held. Release out_ready -> exactly 3 outputs in order, no duplicates.
- In RUN with 2 beats in flight: pulse cfg_start -> mode=DRAIN and in_ready=0. Beats complete; mode=LOAD the cycle after the pipe empties. Write table[8'h03]=2'b01; cfg_done; send 8'h03 -> out_data=2'b01.
- cfg_we=1 with addr 8'h00, data 2'b10 during RUN -> cfg_err=1 and stays set. A subsequent lookup of 8'h00 still returns the old value 2'b00.
- Assert rst with 2 beats buffered and out_ready=0 -> next cycle out_valid=0, mode=LOAD, cfg_err=0. cfg_done then 8'h03 -> 2'b11 (table retained).
- cfg_we plus cfg_done in the same LOAD cycle, writing table[8'hFF]=2'b10 -> mode=RUN next cycle; lookup of 8'hFF returns 2'b10.
